// File: rtl/dsc_mul_seq.sv
// ---------------------------------------------------------------------------
// dsc_mul_seq -- sequential stochastic-computing multiplier.
//
// An operand pair (A, B) is converted into two unipolar stochastic bit
// streams by comparing each operand against one half of a 2*WIDTH-bit frame
// counter. The low half drives A and the high half drives B, so the two
// streams are uncorrelated over a full frame. Their AND is accumulated for
// exactly 2^(2*WIDTH) cycles. Over that frame the count equals A*B exactly.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous reset, active low
//   in_valid   : operand pair present
//   in_ready   : block can accept an operand pair (IDLE and out of reset)
//   in_a, in_b : unsigned operands, WIDTH bits each
//   out_valid  : product valid (DONE), held until out_ready
//   out_ready  : consumer accepts the product
//   product    : 2*WIDTH-bit result; keeps its last value in IDLE and RUN
//   busy       : high in RUN or DONE
//   sn_a/sn_b/sn_y : current stochastic bits (A, B, A&B); zero outside RUN
// ---------------------------------------------------------------------------
module dsc_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               sn_a,
    output logic               sn_b,
    output logic               sn_y
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  ctr_lo_q, ctr_lo_d;
    logic [WIDTH-1:0]  ctr_hi_q, ctr_hi_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     product_q, product_d;

    logic              lo_wrap;
    logic              frame_end;
    logic [PW-1:0]     acc_inc;

    // Low half wrapping is the enable for the high half; both halves at
    // all-ones marks the last cycle of the frame.
    assign lo_wrap   = (ctr_lo_q == {WIDTH{1'b1}});
    assign frame_end = lo_wrap && (ctr_hi_q == {WIDTH{1'b1}});

    // Reset is folded into in_ready so nothing can be accepted while held.
    assign in_ready  = (state_q == S_IDLE) && rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign product   = product_q;

    // Stochastic bits are purely combinational from registers and gated so
    // they read zero in any state other than RUN.
    always_comb begin
        sn_a = 1'b0;
        sn_b = 1'b0;
        if (state_q == S_RUN) begin
            sn_a = (a_q > ctr_lo_q);
            sn_b = (b_q > ctr_hi_q);
        end
        sn_y = sn_a & sn_b;
    end

    assign acc_inc = acc_q + {{(PW-1){1'b0}}, sn_y};

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        ctr_lo_d  = ctr_lo_q;
        ctr_hi_d  = ctr_hi_q;
        acc_d     = acc_q;
        product_d = product_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    ctr_lo_d = '0;
                    ctr_hi_d = '0;
                    acc_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_inc;
                ctr_lo_d = ctr_lo_q + 1'b1;
                if (lo_wrap) begin
                    ctr_hi_d = ctr_hi_q + 1'b1;
                end
                if (frame_end) begin
                    // Final stochastic bit is included in the published result.
                    product_d = acc_inc;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                // No accept can occur on this edge: in_ready is low in DONE.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            ctr_lo_q  <= '0;
            ctr_hi_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ctr_lo_q  <= ctr_lo_d;
            ctr_hi_q  <= ctr_hi_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

endmodule
